// File: rtl/rx_data_merger_pkg.sv
// Shared types and helpers for the receiver data merger.
//   byte_idx_t  : position of the current byte inside a 32-bit word
//   ser_state_t : serialiser state, encoded with the S_* constants
//   clog2()     : elaboration-time ceil(log2(n))
package rx_merger_pkg;

  typedef logic [1:0] byte_idx_t;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  typedef enum logic [0:0] {
    IDLE = S_IDLE,
    SEND = S_SEND
  } ser_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_data_merger_if.sv
// Bus bundle between the receiver FIFOs / SiTCP TX port and the merger.
//   slave  : merger side (sources and TX_FULL in; pops, byte stream, status out)
//   master : environment side (mirror of slave)
interface rx_data_merger_if
  import rx_merger_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 1024
) ();

  localparam int CW = clog2(DEPTH) + 1;
  localparam int GW = (CHANNELS > 1) ? clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]    CH_ENABLE;
  logic [CHANNELS-1:0]    FE_FIFO_EMPTY;
  logic [32*CHANNELS-1:0] FE_FIFO_DATA;
  logic [CHANNELS-1:0]    FE_FIFO_READ;
  logic                   TCP_TX_FULL;
  logic                   TCP_TX_WR;
  logic [7:0]             TCP_TX_DATA;
  logic                   BUF_FULL;
  logic                   BUF_EMPTY;
  logic [CW-1:0]          BUF_COUNT;
  logic [GW-1:0]          LAST_GRANT;

  modport slave (
    input  CH_ENABLE, FE_FIFO_EMPTY, FE_FIFO_DATA, TCP_TX_FULL,
    output FE_FIFO_READ, TCP_TX_WR, TCP_TX_DATA,
           BUF_FULL, BUF_EMPTY, BUF_COUNT, LAST_GRANT
  );

  modport master (
    output CH_ENABLE, FE_FIFO_EMPTY, FE_FIFO_DATA, TCP_TX_FULL,
    input  FE_FIFO_READ, TCP_TX_WR, TCP_TX_DATA,
           BUF_FULL, BUF_EMPTY, BUF_COUNT, LAST_GRANT
  );

endinterface

// File: rtl/rx_data_merger_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward (with wrap)
// from a registered pointer. On advance the pointer moves just past the
// granted channel and last_idx records the granted index.
//   clk_sys, rst_b : clock, async active-low reset
//   req            : per-channel request
//   advance        : the current grant was consumed this cycle
//   grant          : one-hot grant
//   last_idx       : index of the most recently consumed grant
module rr_arbiter
  import rx_merger_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic          clk_sys,
  input  logic          rst_b,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] last_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] next_ptr;
  logic          found;

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  assign next_ptr = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      ptr      <= '0;
      last_idx <= '0;
    end else if (advance) begin
      ptr      <= next_ptr;
      last_idx <= grant_idx;
    end
  end

endmodule

// File: rtl/rx_data_merger.sv
// Merges CHANNELS receiver FIFOs into one SiTCP byte stream:
// round-robin arbiter -> DEPTH x 32-bit buffer FIFO -> 32-to-8 serialiser.
//   BUS_CLK, BUS_RST_N : clock, async active-low reset
//   bus (slave)        : source FIFOs, TCP_TX port, buffer status
//
// Serialiser states:
//   state | meaning
//   IDLE  | shift register empty, waiting for a buffered word
//   SEND  | emitting bytes idx 0..3 of the shift register
module rx_data_merger
  import rx_merger_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 1024,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic               BUS_CLK,
  input logic               BUS_RST_N,
  rx_data_merger_if.slave   bus
);

  localparam int AW = clog2(DEPTH);
  localparam int GW = (CHANNELS > 1) ? clog2(CHANNELS) : 1;

  logic                run;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [GW-1:0]       last_grant;
  logic                wr_en;
  logic                rd_en;
  logic                full;
  logic                empty;
  logic [31:0]         wr_data;
  logic [31:0]         mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  ser_state_t          state;
  byte_idx_t           idx;
  byte_idx_t           sel;
  logic [31:0]         shreg;
  logic                tx_wr;

  // The grant is combinational from source flags, so pops are held off by a
  // flop that is cleared asynchronously and sets on the first edge after release.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) run <= 1'b0;
    else            run <= 1'b1;
  end

  assign req = bus.CH_ENABLE & ~bus.FE_FIFO_EMPTY;

  rr_arbiter #(.N(CHANNELS), .IW(GW)) u_arb (
    .clk_sys  (BUS_CLK),
    .rst_b    (BUS_RST_N),
    .req      (req),
    .advance  (wr_en),
    .grant    (grant),
    .last_idx (last_grant)
  );

  assign bus.FE_FIFO_READ = grant & {CHANNELS{run & ~full}};
  assign wr_en            = |bus.FE_FIFO_READ;

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) wr_data = wr_data | bus.FE_FIFO_DATA[32*i +: 32];
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge BUS_CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign tx_wr = (state == SEND) & ~bus.TCP_TX_FULL;
  // Pop when idle, or right after the last byte so back-to-back words have no bubble.
  assign rd_en = ~empty & ((state == IDLE) | (tx_wr & (idx == 2'd3)));

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
    end else if (rd_en) begin
      shreg <= mem[rd_ptr];
      idx   <= '0;
      state <= SEND;
    end else if (tx_wr) begin
      idx <= idx + 1'b1;
      if (idx == 2'd3) state <= IDLE;
    end
  end

  assign sel             = MSB_FIRST ? ~idx : idx;
  assign bus.TCP_TX_DATA = shreg[{sel, 3'b000} +: 8];
  assign bus.TCP_TX_WR   = tx_wr;
  assign bus.BUF_FULL    = full;
  assign bus.BUF_EMPTY   = empty & (state == IDLE);
  assign bus.BUF_COUNT   = count;
  assign bus.LAST_GRANT  = last_grant;

endmodule

// File: tb/tb_rx_data_merger.sv
// Directed bench for rx_data_merger (CHANNELS=4, DEPTH=16). Source FIFOs are
// queues presented first-word-fall-through; a second instance with
// MSB_FIRST=1 sees the same inputs to cover the other byte order.
module tb_rx_data_merger;
  import rx_merger_pkg::*;

  localparam int CH = 4;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_data_merger_if #(.CHANNELS(CH), .DEPTH(DP)) bus ();
  rx_data_merger_if #(.CHANNELS(CH), .DEPTH(DP)) bus_msb ();

  assign bus_msb.CH_ENABLE     = bus.CH_ENABLE;
  assign bus_msb.FE_FIFO_EMPTY = bus.FE_FIFO_EMPTY;
  assign bus_msb.FE_FIFO_DATA  = bus.FE_FIFO_DATA;
  assign bus_msb.TCP_TX_FULL   = bus.TCP_TX_FULL;

  rx_data_merger #(.CHANNELS(CH), .DEPTH(DP), .MSB_FIRST(1'b0)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .bus(bus));
  rx_data_merger #(.CHANNELS(CH), .DEPTH(DP), .MSB_FIRST(1'b1)) dut_msb (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .bus(bus_msb));

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] src_q [CH][$];
  logic [CH-1:0] pend_pop;
  logic [7:0] got_b[$];
  logic [7:0] got_m[$];
  int rd_ch[$];
  int rd_cyc[$];
  int wr_cyc[$];
  logic [CH-1:0] rd_seen;
  int cyc = 0;
  int onehot_err = 0;
  int wr_full_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input int t, input int c, input int r);
    return {8'(t), 8'(c), 8'(r), 8'(128 + 16*c + r)};
  endfunction

  function automatic logic [31:0] pack4(input logic [7:0] q[$], input bit rev);
    if (q.size() != 4) return 32'hxxxxxxxx;
    return rev ? {q[0], q[1], q[2], q[3]} : {q[3], q[2], q[1], q[0]};
  endfunction

  function automatic logic [63:0] pack_rd(input int q[$]);
    logic [63:0] r = '0;
    foreach (q[i]) r = (r << 2) | 64'(q[i] & 3);
    return r;
  endfunction

  function automatic int stream_errs(input logic [31:0] ew[$], input logic [7:0] gb[$]);
    int e = 0;
    logic [31:0] w;
    if (gb.size() != 4 * ew.size()) e++;
    for (int i = 0; i < gb.size() && i < 4 * ew.size(); i++) begin
      w = ew[i/4];
      if (gb[i] !== w[8*(i%4) +: 8]) e++;
    end
    return e;
  endfunction

  function automatic bit srcs_empty();
    for (int i = 0; i < CH; i++)
      if (bus.CH_ENABLE[i] && src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Output/pop monitor at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      pend_pop = bus.FE_FIFO_READ;
      if ($countones(bus.FE_FIFO_READ) > 1) onehot_err++;
      if (bus.TCP_TX_WR === 1'b1 && bus.TCP_TX_FULL === 1'b1) wr_full_err++;
      for (int i = 0; i < CH; i++) begin
        if (bus.FE_FIFO_READ[i]) begin
          rd_ch.push_back(i);
          rd_cyc.push_back(cyc);
          rd_seen[i] = 1'b1;
        end
      end
      if (bus.TCP_TX_WR === 1'b1) begin
        got_b.push_back(bus.TCP_TX_DATA);
        wr_cyc.push_back(cyc);
      end
      if (bus_msb.TCP_TX_WR === 1'b1) got_m.push_back(bus_msb.TCP_TX_DATA);
    end
  end

  // Source FIFO model: apply pops taken at the edge, then present the new heads.
  initial begin
    bus.FE_FIFO_EMPTY = '1;
    bus.FE_FIFO_DATA  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) begin
        if (pend_pop[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        bus.FE_FIFO_EMPTY[i] = (src_q[i].size() == 0);
        bus.FE_FIFO_DATA[32*i +: 32] = (src_q[i].size() > 0) ? src_q[i][0] : 32'h0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    got_b.delete(); got_m.delete(); rd_ch.delete(); rd_cyc.delete(); wr_cyc.delete();
    rd_seen = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 600) begin
      step(1);
      n++;
      if (bus.BUF_EMPTY === 1'b1 && srcs_empty()) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle"}, 64'(quiet >= 3), 64'd1);
  endtask

  logic [31:0] exp_w[$];

  initial begin
    pend_pop = '0;
    rd_seen = '0;
    bus.CH_ENABLE = 4'b0001;
    bus.TCP_TX_FULL = 1'b0;
    src_q[0].push_back(32'h44332211);

    // Reset state, with ch0 requesting.
    step(4);
    check("rst_count", 64'(bus.BUF_COUNT), 64'd0);
    check("rst_full", 64'(bus.BUF_FULL), 64'd0);
    check("rst_empty", 64'(bus.BUF_EMPTY), 64'd1);
    check("rst_grant", 64'(bus.LAST_GRANT), 64'd0);
    check("rst_read", 64'(bus.FE_FIFO_READ), 64'd0);
    check("rst_wr", 64'(bus.TCP_TX_WR), 64'd0);

    // Single channel, both byte orders, latency.
    clear_logs();
    rst_n = 1'b1;
    wait_idle("t1");
    check("t1_reads", 64'(rd_ch.size()), 64'd1);
    check("t1_bytes_lsb", 64'(pack4(got_b, 1'b0)), 64'h44332211);
    check("t1_bytes_msb", 64'(pack4(got_m, 1'b1)), 64'h44332211);
    if (rd_cyc.size() > 0 && wr_cyc.size() == 4) begin
      check("t1_latency", 64'(wr_cyc[0] - rd_cyc[0]), 64'd2);
      check("t1_back2back", 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);
    end else begin
      check("t1_log_sizes", 64'(wr_cyc.size()), 64'd4);
    end

    // All four channels, 3 words each.
    do_reset();
    clear_logs();
    exp_w.delete();
    bus.CH_ENABLE = 4'b1111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < CH; c++) begin
        src_q[c].push_back(mkw(2, c, r));
        exp_w.push_back(mkw(2, c, r));
      end
    wait_idle("t2");
    check("t2_order", pack_rd(rd_ch), 64'h1B1B1B);
    check("t2_nbytes", 64'(got_b.size()), 64'd48);
    check("t2_stream", 64'(stream_errs(exp_w, got_b)), 64'd0);
    check("t2_last_grant", 64'(bus.LAST_GRANT), 64'd3);
    if (rd_cyc.size() == 12 && wr_cyc.size() == 48) begin
      check("t2_in_rate", 64'(rd_cyc[11] - rd_cyc[0]), 64'd11);
      check("t2_out_rate", 64'(wr_cyc[47] - wr_cyc[0]), 64'd47);
    end else begin
      check("t2_log_sizes", 64'(rd_cyc.size()), 64'd12);
    end

    // Backpressure: buffer fills to DEPTH, then drains in order.
    clear_logs();
    exp_w.delete();
    bus.TCP_TX_FULL = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < CH; c++) begin
        src_q[c].push_back(mkw(3, c, r));
        exp_w.push_back(mkw(3, c, r));
      end
    step(100);
    check("t3_count_sat", 64'(bus.BUF_COUNT), 64'd16);
    check("t3_full", 64'(bus.BUF_FULL), 64'd1);
    check("t3_read_held", 64'(bus.FE_FIFO_READ), 64'd0);
    check("t3_wr_held", 64'(bus.TCP_TX_WR), 64'd0);
    check("t3_reads_taken", 64'(rd_ch.size()), 64'd17);
    bus.TCP_TX_FULL = 1'b0;
    wait_idle("t3");
    check("t3_nbytes", 64'(got_b.size()), 64'd96);
    check("t3_stream", 64'(stream_errs(exp_w, got_b)), 64'd0);

    // Random TCP_TX_FULL toggling mid-word.
    clear_logs();
    exp_w.delete();
    wr_full_err = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++) begin
        src_q[c].push_back(mkw(4, c, r));
        exp_w.push_back(mkw(4, c, r));
      end
    for (int n = 0; n < 60; n++) begin
      bus.TCP_TX_FULL = 1'($urandom_range(0, 1));
      step(1);
    end
    bus.TCP_TX_FULL = 1'b0;
    wait_idle("t4");
    check("t4_stream", 64'(stream_errs(exp_w, got_b)), 64'd0);
    check("t4_wr_while_full", 64'(wr_full_err), 64'd0);

    // Channel enables 0101 with all sources non-empty.
    clear_logs();
    exp_w.delete();
    bus.CH_ENABLE = 4'b0101;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++) src_q[c].push_back(mkw(5, c, r));
    for (int r = 0; r < 2; r++) begin
      exp_w.push_back(mkw(5, 0, r));
      exp_w.push_back(mkw(5, 2, r));
    end
    wait_idle("t5");
    check("t5_order", pack_rd(rd_ch), 64'h22);
    check("t5_seen", 64'(rd_seen), 64'h5);
    check("t5_stream", 64'(stream_errs(exp_w, got_b)), 64'd0);
    check("t5_last_grant", 64'(bus.LAST_GRANT), 64'd2);
    bus.CH_ENABLE = 4'b0000;
    src_q[1].delete();
    src_q[3].delete();
    step(2);

    // Reset pulsed mid-word.
    clear_logs();
    bus.CH_ENABLE = 4'b0001;
    src_q[0].push_back(32'h11111111);
    src_q[0].push_back(32'h22222222);
    begin
      int n = 0;
      while (got_b.size() < 2 && n < 50) begin
        step(1);
        n++;
      end
    end
    check("t6_mid_word", 64'(got_b.size() >= 2 && got_b.size() < 4), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_wr_in_rst", 64'(bus.TCP_TX_WR), 64'd0);
    check("t6_read_in_rst", 64'(bus.FE_FIFO_READ), 64'd0);
    step(2);
    src_q[0].delete();
    rst_n = 1'b1;
    step(1);
    check("t6_count", 64'(bus.BUF_COUNT), 64'd0);
    check("t6_empty", 64'(bus.BUF_EMPTY), 64'd1);
    clear_logs();
    src_q[0].push_back(32'hDDCCBBAA);
    wait_idle("t6");
    check("t6_restart", 64'(pack4(got_b, 1'b0)), 64'hDDCCBBAA);

    check("onehot_reads", 64'(onehot_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
